// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF sweep scheduler and the LIF core.
package lif_pkg;

  // Default neuron count and potential width shared with the LIF core.
  localparam int unsigned NUM_NEURONS_DEFAULT = 4;
  localparam int unsigned WIDTH_DEFAULT       = 8;

  localparam int unsigned IDX_W    = $clog2(NUM_NEURONS_DEFAULT);
  localparam int unsigned REFRAC_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REQ,
    DONE
  } sched_state_t;

endpackage

// File: rtl/lif_tick_prescaler.sv
// Free-running tick prescaler: one-cycle tick every PRESCALE enabled cycles.
module lif_tick_prescaler #(
  parameter int unsigned PRESCALE = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned   CntW = $clog2(PRESCALE);
  localparam logic [CntW-1:0] Last = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: advance and wrap only while enabled, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by enable so a held count of PRESCALE-1 does not repeat the tick.
  assign tick = enable && (cnt_q == Last);

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Time-multiplexes one LIF update datapath across NUM_NEURONS virtual neurons.
// Each tick starts a sweep that serves every non-refractory neuron in order.
module lif_sweep_scheduler
  import lif_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned WIDTH       = WIDTH_DEFAULT,
  parameter int unsigned PRESCALE    = 10_000_000,
  parameter int unsigned REFRAC      = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [NUM_NEURONS-1:0]         stim,
  output logic                           dp_req,
  output logic [$clog2(NUM_NEURONS)-1:0] dp_idx,
  output logic [WIDTH-1:0]               dp_v_in,
  output logic                           dp_stim,
  input  logic                           dp_ack,
  input  logic [WIDTH-1:0]               dp_v_out,
  input  logic                           dp_fire,
  output logic [NUM_NEURONS-1:0]         spike,
  output logic                           busy,
  output logic                           sweep_done,
  output logic                           overrun
);

  localparam int unsigned         IdxW       = $clog2(NUM_NEURONS);
  localparam logic [IdxW-1:0]     LastIdx    = IdxW'(NUM_NEURONS - 1);
  localparam logic [REFRAC_W-1:0] RefracInit = REFRAC_W'(REFRAC);

  logic tick;

  sched_state_t               state_q;
  logic [IdxW-1:0]            idx_q;
  logic [WIDTH-1:0]           v_q      [NUM_NEURONS];
  logic [REFRAC_W-1:0]        refrac_q [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]     stim_q;
  logic [NUM_NEURONS-1:0]     spike_q;
  logic                       req_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       overrun_q;

  lif_tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .tick   (tick)
  );

  // Sweep FSM and per-neuron register file; all outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      stim_q    <= '0;
      spike_q   <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      // A tick that lands outside IDLE is dropped but remembered.
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            stim_q  <= stim;
            spike_q <= '0;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (refrac_q[idx_q] != '0) begin
            // Refractory neuron: count down and skip the datapath.
            refrac_q[idx_q] <= refrac_q[idx_q] - REFRAC_W'(1);
            if (idx_q == LastIdx) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= CHECK;
            end
          end else begin
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (dp_ack) begin
            req_q <= 1'b0;
            if (dp_fire) begin
              v_q[idx_q]      <= '0;
              refrac_q[idx_q] <= RefracInit;
              spike_q[idx_q]  <= 1'b1;
            end else begin
              v_q[idx_q] <= dp_v_out;
            end
            if (idx_q == LastIdx) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              idx_q   <= idx_q + IdxW'(1);
              state_q <= CHECK;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operands come straight from the register file; they cannot change in REQ.
  assign dp_req     = req_q;
  assign dp_idx     = idx_q;
  assign dp_v_in    = v_q[idx_q];
  assign dp_stim    = stim_q[idx_q];
  assign spike      = spike_q;
  assign busy       = busy_q;
  assign sweep_done = done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Self-checking bench: sweep-level schedule model plus directed literal checks.
module tb_lif_sweep_scheduler;

  localparam int N = 4;
  localparam int W = 8;
  localparam int P = 16;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [N-1:0] stim;
  logic         dp_req;
  logic [1:0]   dp_idx;
  logic [W-1:0] dp_v_in;
  logic         dp_stim;
  logic         dp_ack;
  logic [W-1:0] dp_v_out;
  logic         dp_fire;
  logic [N-1:0] spike;
  logic         busy;
  logic         sweep_done;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lif_sweep_scheduler #(
    .NUM_NEURONS (N),
    .WIDTH       (W),
    .PRESCALE    (P),
    .REFRAC      (R)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .stim       (stim),
    .dp_req     (dp_req),
    .dp_idx     (dp_idx),
    .dp_v_in    (dp_v_in),
    .dp_stim    (dp_stim),
    .dp_ack     (dp_ack),
    .dp_v_out   (dp_v_out),
    .dp_fire    (dp_fire),
    .spike      (spike),
    .busy       (busy),
    .sweep_done (sweep_done),
    .overrun    (overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (sweep schedule) ----------------
  bit           m_valid = 1'b0;
  int           pc;
  int           m_v   [N];
  int           m_ref [N];
  logic [N-1:0] m_spike;
  bit           m_overrun;
  bit           sw_on;
  int           t;
  int           done_off;
  int           s_start [N];
  bit           s_srv   [N];
  logic [N-1:0] snap;
  int           sw_delay = 0;
  int           next_delay = 0;

  // Per cycle: compare outputs to the model, then advance the model one clock.
  always @(negedge clk) begin
    bit e_req;
    int e_i;
    bit busy_now;
    bit tick_now;
    int off;
    int nv;
    e_req = 1'b0;
    e_i   = 0;
    if (m_valid) begin
      if (sw_on) begin
        for (int i = 0; i < N; i++) begin
          if (s_srv[i] && t >= s_start[i] && t <= s_start[i] + sw_delay) begin
            e_req = 1'b1;
            e_i   = i;
          end
        end
      end
      chk("busy", 32'(busy), 32'(sw_on));
      chk("sweep_done", 32'(sweep_done), 32'(sw_on && t == done_off));
      chk("overrun", 32'(overrun), 32'(m_overrun));
      chk("spike", 32'(spike), 32'(m_spike));
      chk("dp_req", 32'(dp_req), 32'(e_req));
      if (e_req) begin
        chk("dp_idx", 32'(dp_idx), 32'(e_i));
        chk("dp_v_in", 32'(dp_v_in), 32'(m_v[e_i]));
        chk("dp_stim", 32'(dp_stim), 32'(snap[e_i]));
      end
    end

    if (rst_n !== 1'b1) begin
      pc        = 0;
      m_spike   = '0;
      m_overrun = 1'b0;
      sw_on     = 1'b0;
      t         = 0;
      for (int i = 0; i < N; i++) begin
        m_v[i]   = 0;
        m_ref[i] = 0;
        s_srv[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      tick_now = enable && (pc == P - 1);
      if (enable) pc = (pc == P - 1) ? 0 : pc + 1;
      busy_now = sw_on;
      if (sw_on) begin
        for (int i = 0; i < N; i++) begin
          if (s_srv[i] && t == s_start[i] + sw_delay) begin
            nv = m_v[i] + (snap[i] ? 16 : 0);
            if (nv >= 48) begin
              m_v[i]     = 0;
              m_ref[i]   = R;
              m_spike[i] = 1'b1;
            end else begin
              m_v[i] = nv;
            end
          end
        end
        if (t == done_off) sw_on = 1'b0;
        else t++;
      end
      if (tick_now) begin
        if (busy_now) begin
          m_overrun = 1'b1;
        end else begin
          // Lay out the whole sweep: refractory neurons cost 1 cycle,
          // served ones 1 CHECK plus (delay+1) REQ cycles.
          snap     = stim;
          m_spike  = '0;
          sw_delay = next_delay;
          off      = 1;
          for (int i = 0; i < N; i++) begin
            if (m_ref[i] != 0) begin
              s_srv[i] = 1'b0;
              m_ref[i]--;
              off += 1;
            end else begin
              s_srv[i]   = 1'b1;
              s_start[i] = off + 1;
              off += 2 + sw_delay;
            end
          end
          done_off = off;
          t        = 1;
          sw_on    = 1'b1;
        end
      end
    end
  end

  // ---------------- bench datapath: v_out = v_in + 16*stim, fire at >= 48 ----------------
  initial begin
    int wcnt;
    int v;
    wcnt     = 0;
    dp_ack   = 1'b0;
    dp_v_out = '0;
    dp_fire  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      dp_ack = 1'b0;
      if (dp_req === 1'b1) begin
        if (wcnt >= sw_delay) begin
          v        = int'(dp_v_in) + (dp_stim ? 16 : 0);
          dp_v_out = W'(v);
          dp_fire  = (v >= 48);
          dp_ack   = 1'b1;
          wcnt     = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // ---------------- stimulus and literal checks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (sweep_done !== 1'b1 && n < 400);
    chk(name, 32'(sweep_done), 32'd1);
  endtask

  task automatic wait_req0(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(dp_req === 1'b1 && dp_idx == 2'd0) && n < 400);
    chk(name, 32'(dp_req), 32'd1);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    enable = 1'b0;
    stim   = '0;
    repeat (3) step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req", 32'(dp_req), 32'd0);
    chk("reset_spike", 32'(spike), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    stim   = 4'b0101;

    // First tick lands P cycles after release; busy shows the cycle after.
    n = 0;
    do begin
      step();
      n++;
    end while (busy !== 1'b1 && n < 100);
    chk("first_tick_latency", 32'(n), 32'(P));
    n = 0;
    do begin
      step();
      n++;
    end while (sweep_done !== 1'b1 && n < 100);
    chk("sweep1_len", 32'(n), 32'd8);
    chk("sweep1_spike", 32'(spike), 32'd0);

    wait_req0("sweep2_req0_seen");
    chk("sweep2_v0", 32'(dp_v_in), 32'd16);
    wait_done("sweep2_done");
    wait_done("sweep3_done");
    chk("sweep3_spike", 32'(spike), 32'b0101);
    wait_done("sweep4_done");
    chk("sweep4_spike", 32'(spike), 32'd0);
    wait_done("sweep5_done");
    chk("sweep5_spike", 32'(spike), 32'd0);
    wait_req0("sweep6_req0_seen");
    chk("sweep6_v0", 32'(dp_v_in), 32'd0);
    wait_done("sweep6_done");
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Enable gating: prescaler freezes, no sweep starts.
    enable = 1'b0;
    repeat (30) begin
      step();
    end
    chk("gated_busy", 32'(busy), 32'd0);
    enable = 1'b1;

    // Randomized phase: stimulus, ack latency and enable gaps.
    repeat (40) begin
      stim       = 4'($urandom_range(0, 15));
      next_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 20)) step();
        enable = 1'b1;
      end
      repeat ($urandom_range(5, 40)) step();
    end

    // Reset while a request is outstanding.
    next_delay = 3;
    stim       = 4'b1111;
    n = 0;
    do begin
      step();
      n++;
    end while (dp_req !== 1'b1 && n < 400);
    chk("pre_reset_req_seen", 32'(dp_req), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_req", 32'(dp_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_spike", 32'(spike), 32'd0);
    chk("midrst_overrun", 32'(overrun), 32'd0);
    step();
    rst_n = 1'b1;

    // Stalled acks: operands held, overlapping tick dropped and flagged.
    next_delay = 20;
    wait_done("stall_done");
    chk("stall_overrun", 32'(overrun), 32'd1);
    next_delay = 0;
    repeat (100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
